// File: rtl/dmem_access_if.sv
// Bus bundle for the data-memory responder.
//   Request side  : v_i, stall_o, we_i, addr_i, data_i, rd_name_i
//   SRAM side     : mem_a_o, mem_w_o, mem_d_o, mem_q_i
//   Writeback side: wb_o, wb_rd_name_o, wb_rd_data_o, wb_stall_i
//   Status        : busy_o
// Member names keep the original port names. The _i/_o suffixes are relative
// to dmem_access, which connects through the slave modport.
interface dmem_access_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned RD_W   = 5
);
  logic              v_i;
  logic              stall_o;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [WORD_W-1:0] data_i;
  logic [RD_W-1:0]   rd_name_i;
  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_w_o;
  logic [WORD_W-1:0] mem_d_o;
  logic [WORD_W-1:0] mem_q_i;
  logic              wb_o;
  logic [RD_W-1:0]   wb_rd_name_o;
  logic [WORD_W-1:0] wb_rd_data_o;
  logic              wb_stall_i;
  logic              busy_o;

  modport slave (
    input  v_i, we_i, addr_i, data_i, rd_name_i, mem_q_i, wb_stall_i,
    output stall_o, mem_a_o, mem_w_o, mem_d_o,
           wb_o, wb_rd_name_o, wb_rd_data_o, busy_o
  );

  modport master (
    output v_i, we_i, addr_i, data_i, rd_name_i, mem_q_i, wb_stall_i,
    input  stall_o, mem_a_o, mem_w_o, mem_d_o,
           wb_o, wb_rd_name_o, wb_rd_data_o, busy_o
  );
endinterface

// File: rtl/dmem_access.sv
// Data-memory responder for the Venus core.
// Accepts load/store requests (v_i/stall_o handshake) and drives the
// synchronous data SRAM, which has one-cycle read latency. A load sets an
// in-flight flag for one cycle, and the returning SRAM word is captured with
// its destination tag into an in-order return FIFO. The FIFO head drives the
// writeback port, and wb_stall_i holds it.
// Ports:
//   clk - clock
//   rst - asynchronous, active-high reset
//   bus - dmem_access_if.slave (request, SRAM, writeback, busy)
module dmem_access #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_access_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic              inflight;
  logic [RD_W-1:0]   tag;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [RD_W-1:0]   fifo_name [DEPTH];
  logic [WORD_W-1:0] fifo_data [DEPTH];

  logic        acc;
  logic        ld_acc;
  logic        pop;
  logic        push;
  logic        stall;
  logic [CW:0] level;

  // Credit check: the in-flight load and the entry leaving this cycle both
  // count. A push can therefore never find the FIFO full.
  always_comb begin
    push   = inflight;
    pop    = (count != '0) & ~bus.wb_stall_i;
    level  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    stall  = (level >= DEPTH_L);
    acc    = bus.v_i & ~stall;
    ld_acc = acc & ~bus.we_i;
  end

  assign bus.stall_o      = stall;
  assign bus.mem_a_o      = bus.addr_i;
  assign bus.mem_d_o      = bus.data_i;
  assign bus.mem_w_o      = acc & bus.we_i & ~rst;
  assign bus.wb_o         = (count != '0);
  assign bus.wb_rd_name_o = fifo_name[rd_ptr];
  assign bus.wb_rd_data_o = fifo_data[rd_ptr];
  assign bus.busy_o       = inflight | (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= ld_acc;
      if (ld_acc) tag <= bus.rd_name_i;
    end
  end

  // Storage is reset as well, so the head outputs read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_name[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else if (push) begin
      fifo_name[wr_ptr] <= tag;
      fifo_data[wr_ptr] <= bus.mem_q_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
